// File: rtl/my_in_cond2.sv
// my_in_cond2 -- two-channel input conditioner feeding the 2-input AND gate stage.
//
// Each raw asynchronous level (a_in, b_in) goes through a 2-flop synchronizer
// and a counter-based debouncer. A channel's output flips only after the
// synchronized input has disagreed with it for CNT_MAX consecutive
// qualification cycles. Any reversion of the input restarts the count.
//
// Parameters:
//   CNT_W    width of each channel's debounce counter
//   CNT_MAX  mismatching cycles before a flip (legal range 2 .. 2^CNT_W-1)
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   a_in     raw input, channel A
//   b_in     raw input, channel B
//   a_out    debounced level, channel A (gate input a)
//   b_out    debounced level, channel B (gate input b)
//   settled  high while both channels sit in STABLE
//
// Optional (macro MY_IN_COND2_EDGE_EN defined):
//   a_rise, a_fall, b_rise, b_fall  one-cycle pulses, high in the cycle the
//                                   corresponding output first shows its new level

module my_in_cond2_chan #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned CNT_MAX = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic x_in,
    output logic x_out,
    output logic stable
`ifdef MY_IN_COND2_EDGE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    typedef enum logic {STABLE = 1'b0, CHECK = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1, s2;
    logic             lvl_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    state_t           state, state_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lvl_nxt   = x_out;
        case (state)
            STABLE: begin
                cnt_nxt = '0;
                if (s2 != x_out) begin
                    state_nxt = CHECK;
                    cnt_nxt   = CNT_ONE;
                end
            end
            CHECK: begin
                if (s2 == x_out) begin
                    // input reverted: glitch rejected
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    // counter is cleared here, so it can never wrap
                    lvl_nxt   = ~x_out;
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= STABLE;
            cnt   <= '0;
            x_out <= 1'b0;
        end else begin
            s1    <= x_in;
            s2    <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            x_out <= lvl_nxt;
        end
    end

    assign stable = (state == STABLE);

`ifdef MY_IN_COND2_EDGE_EN
    // Registered alongside x_out, so each pulse coincides with the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= lvl_nxt & ~x_out;
            fall <= ~lvl_nxt & x_out;
        end
    end
`endif

endmodule

module my_in_cond2 #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned CNT_MAX = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_in,
    input  logic b_in,
    output logic a_out,
    output logic b_out,
    output logic settled
`ifdef MY_IN_COND2_EDGE_EN
    ,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
`endif
);

    logic a_stable, b_stable;

    my_in_cond2_chan #(
        .CNT_W   (CNT_W),
        .CNT_MAX (CNT_MAX)
    ) u_chan_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .x_in   (a_in),
        .x_out  (a_out),
        .stable (a_stable)
`ifdef MY_IN_COND2_EDGE_EN
        ,
        .rise   (a_rise),
        .fall   (a_fall)
`endif
    );

    my_in_cond2_chan #(
        .CNT_W   (CNT_W),
        .CNT_MAX (CNT_MAX)
    ) u_chan_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .x_in   (b_in),
        .x_out  (b_out),
        .stable (b_stable)
`ifdef MY_IN_COND2_EDGE_EN
        ,
        .rise   (b_rise),
        .fall   (b_fall)
`endif
    );

    // Decoded straight from the state flops: no added latency.
    assign settled = a_stable & b_stable;

endmodule

// File: tb/tb_my_in_cond2.sv
module tb_my_in_cond2;

    logic clk;
    logic rst_n;
    logic a_in, b_in;
    logic a_out, b_out, settled;
`ifdef MY_IN_COND2_EDGE_EN
    logic a_rise, a_fall, b_rise, b_fall;
`endif

    int unsigned n_total;
    int unsigned n_bad;

    my_in_cond2 #(
        .CNT_W   (4),
        .CNT_MAX (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_in    (a_in),
        .b_in    (b_in),
        .a_out   (a_out),
        .b_out   (b_out),
        .settled (settled)
`ifdef MY_IN_COND2_EDGE_EN
        ,
        .a_rise  (a_rise),
        .a_fall  (a_fall),
        .b_rise  (b_rise),
        .b_fall  (b_fall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // advance one rising edge, return 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        a_in    = 1'b0;
        b_in    = 1'b0;

        // reset hold: random input activity must not reach the outputs
        for (int i = 0; i < 8; i++) begin
            a_in = 1'($urandom_range(0, 1));
            b_in = 1'($urandom_range(0, 1));
            step();
            check("rst_a_out", a_out, 0);
            check("rst_b_out", b_out, 0);
            check("rst_settled", settled, 1);
`ifdef MY_IN_COND2_EDGE_EN
            check("rst_pulses", {a_rise, a_fall, b_rise, b_fall}, 0);
`endif
        end
        a_in = 1'b0;
        b_in = 1'b0;
        #3 rst_n = 1'b1;
        idle(4);
        check("idle_a_out", a_out, 0);
        check("idle_settled", settled, 1);

        // clean step on A: flip at edge k+5, settled low k+2..k+4
        a_in = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            step();
            check($sformatf("step_a_out_e%0d", e), a_out, (e >= 5) ? 1 : 0);
            check($sformatf("step_settled_e%0d", e), settled, (e >= 2 && e < 5) ? 0 : 1);
            check($sformatf("step_b_out_e%0d", e), b_out, 0);
`ifdef MY_IN_COND2_EDGE_EN
            check($sformatf("step_a_rise_e%0d", e), a_rise, (e == 5) ? 1 : 0);
            check($sformatf("step_a_fall_e%0d", e), a_fall, 0);
`endif
        end

        // release on A: falls at edge k+5
        a_in = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            step();
            check($sformatf("rel_a_out_e%0d", e), a_out, (e >= 5) ? 0 : 1);
            check($sformatf("rel_settled_e%0d", e), settled, (e >= 2 && e < 5) ? 0 : 1);
`ifdef MY_IN_COND2_EDGE_EN
            check($sformatf("rel_a_fall_e%0d", e), a_fall, (e == 5) ? 1 : 0);
            check($sformatf("rel_a_rise_e%0d", e), a_rise, 0);
`endif
        end

        // glitch on B: high for 3 sampling edges, counter reaches CNT_MAX-1 then reverts
        b_in = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            step();
            if (e == 2) b_in = 1'b0;
            check($sformatf("gl_b_out_e%0d", e), b_out, 0);
            check($sformatf("gl_settled_e%0d", e), settled, (e >= 2 && e <= 4) ? 0 : 1);
`ifdef MY_IN_COND2_EDGE_EN
            check($sformatf("gl_b_rise_e%0d", e), b_rise, 0);
`endif
        end

        // simultaneous rise on both channels
        a_in = 1'b1;
        b_in = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            step();
            check($sformatf("sim_a_out_e%0d", e), a_out, (e >= 5) ? 1 : 0);
            check($sformatf("sim_b_out_e%0d", e), b_out, (e >= 5) ? 1 : 0);
            check($sformatf("sim_settled_e%0d", e), settled, (e >= 2 && e < 5) ? 0 : 1);
`ifdef MY_IN_COND2_EDGE_EN
            check($sformatf("sim_rise_e%0d", e), {a_rise, b_rise}, (e == 5) ? 2'b11 : 2'b00);
`endif
        end

        // return both low before the mid-count reset test
        a_in = 1'b0;
        b_in = 1'b0;
        idle(8);
        check("pre_mid_outs", {a_out, b_out}, 2'b00);
        check("pre_mid_settled", settled, 1);

        // mid-count reset: partial count discarded
        a_in = 1'b1;
        for (int e = 0; e <= 3; e++) step();
        check("mid_pre_settled", settled, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_a_out", a_out, 0);
        check("mid_rst_settled", settled, 1);
        #2 rst_n = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            step();
            check($sformatf("mid_a_out_e%0d", e), a_out, (e >= 5) ? 1 : 0);
            check($sformatf("mid_settled_e%0d", e), settled, (e >= 2 && e < 5) ? 0 : 1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
